// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared types and helpers for the load/store memory stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_width_e;

  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } mem_sign_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Access size in bytes for a width encoding.
  function automatic logic [3:0] width_to_size(input logic [1:0] width);
    return 4'd1 << width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Brief   : Extracts the addressed bytes from a bus word and sign/zero-extends.
// Revision: 1.0 - initial release
// ============================================================================
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              rdata_i,
  input  logic [$clog2(XLEN/8)-1:0]    lane_i,
  input  logic [1:0]                   width_i,
  input  logic                         sign_i,
  output logic [XLEN-1:0]              data_o
);

  logic [XLEN-1:0] shifted;
  logic            msb;
  logic            ext;
  int              nbits;

  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    nbits   = int'(width_to_size(width_i)) * 8;
    case (width_i)
      BYTE:    msb = shifted[7];
      HALF:    msb = shifted[15];
      WORD:    msb = shifted[31];
      default: msb = shifted[XLEN-1];
    endcase
    ext    = sign_i & msb;
    data_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      data_o[i] = (i < nbits) ? shifted[i] : ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_stage
// Brief   : Load/store memory stage with req/gnt/rvalid bus and MEM/WB register.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [1:0]           mem_width_i,
  input  logic                 mem_sign_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic                 stall_i,
  input  logic                 squash_i,
  output logic                 dmem_req_o,
  input  logic                 dmem_gnt_i,
  output logic                 dmem_we_o,
  output logic [ADDR_W-1:0]    dmem_addr_o,
  output logic [XLEN/8-1:0]    dmem_be_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_rvalid_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic                 valid_o,
  output logic [XLEN-1:0]      load_data_o,
  output logic                 misalign_o,
  output logic                 busy_o
);

  localparam int NBYTES = XLEN / 8;
  localparam int LANE_W = $clog2(NBYTES);

  lsu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NBYTES-1:0]   be_q, be_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [1:0]          width_q, width_d;
  logic                sign_q, sign_d;
  logic                killed_q, killed_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                valid_q, valid_d;
  logic                misalign_q, misalign_d;
  logic [XLEN-1:0]     load_data_q, load_data_d;

  logic                access;
  logic                misaligned;
  logic                start;
  logic                wb_en;
  logic [LANE_W-1:0]   lane;
  logic [NBYTES-1:0]   be_base;
  logic [XLEN-1:0]     load_fmt;

  assign access = valid_i & (mem_read_i | mem_write_i);
  assign lane   = addr_i[LANE_W-1:0];

  always_comb begin
    misaligned = 1'b0;
    case (mem_width_i)
      HALF:    misaligned = addr_i[0];
      WORD:    misaligned = |addr_i[1:0];
      DOUBLE:  misaligned = (XLEN == 32) || (|addr_i[2:0]);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    be_base = '0;
    for (int i = 0; i < NBYTES; i++) begin
      be_base[i] = (i < int'(width_to_size(mem_width_i)));
    end
  end

  assign start  = (state_q == IDLE) & access & ~misaligned & ~squash_i;
  assign busy_o = (state_q == REQ) | (state_q == RSP) | start;
  assign wb_en  = ~stall_i & ~busy_o;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata_i (dmem_rdata_i),
    .lane_i  (addr_q[LANE_W-1:0]),
    .width_i (width_q),
    .sign_i  (sign_q),
    .data_o  (load_fmt)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    width_d     = width_q;
    sign_d      = sign_q;
    killed_d    = killed_q;
    result_d    = result_q;
    valid_d     = valid_q;
    misalign_d  = misalign_q;
    load_data_d = load_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = addr_i;
          be_d     = be_base << lane;
          wdata_d  = wdata_i << {lane, 3'b000};
          we_d     = mem_write_i;
          width_d  = mem_width_i;
          sign_d   = mem_sign_i;
          killed_d = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // A squash here cannot withdraw the request; remember it for valid_o.
        killed_d = killed_q | squash_i;
        if (dmem_gnt_i) begin
          state_d = we_q ? DONE : RSP;
        end
      end
      RSP: begin
        killed_d = killed_q | squash_i;
        if (dmem_rvalid_i) begin
          result_d = load_fmt;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wb_en) begin
      valid_d     = valid_i & ~squash_i & ~((state_q == DONE) & killed_q);
      misalign_d  = access & misaligned;
      load_data_d = ((state_q == DONE) && !we_q) ? result_q : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      width_q     <= 2'd0;
      sign_q      <= 1'b0;
      killed_q    <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      width_q     <= width_d;
      sign_q      <= sign_d;
      killed_q    <= killed_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign valid_o      = valid_q;
  assign misalign_o   = misalign_q;
  assign load_data_o  = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_lsu_mem_stage
// Brief   : Directed scoreboard bench for XLEN=32 and XLEN=64 instances.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // XLEN=32 instance signals
  logic        a_valid, a_rd, a_wr, a_sign, a_stall, a_squash, a_gnt, a_rvalid;
  logic [1:0]  a_width;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_req, a_we, a_vo, a_mis, a_busy;
  logic [31:0] a_daddr, a_dwdata, a_ld;
  logic [3:0]  a_be;

  // XLEN=64 instance signals
  logic        b_valid, b_rd, b_wr, b_sign, b_stall, b_squash, b_gnt, b_rvalid;
  logic [1:0]  b_width;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic        b_req, b_we, b_vo, b_mis, b_busy;
  logic [31:0] b_daddr;
  logic [63:0] b_dwdata, b_ld;
  logic [7:0]  b_be;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .mem_read_i(a_rd), .mem_write_i(a_wr),
    .mem_width_i(a_width), .mem_sign_i(a_sign), .addr_i(a_addr), .wdata_i(a_wdata),
    .stall_i(a_stall), .squash_i(a_squash), .dmem_req_o(a_req), .dmem_gnt_i(a_gnt),
    .dmem_we_o(a_we), .dmem_addr_o(a_daddr), .dmem_be_o(a_be), .dmem_wdata_o(a_dwdata),
    .dmem_rvalid_i(a_rvalid), .dmem_rdata_i(a_rdata), .valid_o(a_vo),
    .load_data_o(a_ld), .misalign_o(a_mis), .busy_o(a_busy)
  );

  lsu_mem_stage #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .mem_read_i(b_rd), .mem_write_i(b_wr),
    .mem_width_i(b_width), .mem_sign_i(b_sign), .addr_i(b_addr), .wdata_i(b_wdata),
    .stall_i(b_stall), .squash_i(b_squash), .dmem_req_o(b_req), .dmem_gnt_i(b_gnt),
    .dmem_we_o(b_we), .dmem_addr_o(b_daddr), .dmem_be_o(b_be), .dmem_wdata_o(b_dwdata),
    .dmem_rvalid_i(b_rvalid), .dmem_rdata_i(b_rdata), .valid_o(b_vo),
    .load_data_o(b_ld), .misalign_o(b_mis), .busy_o(b_busy)
  );

  typedef struct packed {
    logic        v;
    logic        m;
    logic [63:0] d;
  } wb_t;

  wb_t q32[$];
  wb_t q64[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop32(input string tag);
    wb_t e;
    if (q32.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      e = q32.pop_front();
      chk({tag, ".valid"},    {63'b0, a_vo},  {63'b0, e.v});
      chk({tag, ".misalign"}, {63'b0, a_mis}, {63'b0, e.m});
      chk({tag, ".data"},     {32'b0, a_ld},  e.d);
    end
  endtask

  task automatic pop64(input string tag);
    wb_t e;
    if (q64.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      e = q64.pop_front();
      chk({tag, ".valid"},    {63'b0, b_vo},  {63'b0, e.v});
      chk({tag, ".misalign"}, {63'b0, b_mis}, {63'b0, e.m});
      chk({tag, ".data"},     b_ld,           e.d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv32(input logic v, input logic rd, input logic wr, input logic [1:0] w,
                       input logic s, input logic [31:0] ad, input logic [31:0] wd);
    a_valid = v; a_rd = rd; a_wr = wr; a_width = w; a_sign = s; a_addr = ad; a_wdata = wd;
  endtask

  task automatic drv64(input logic v, input logic rd, input logic wr, input logic [1:0] w,
                       input logic s, input logic [31:0] ad, input logic [63:0] wd);
    b_valid = v; b_rd = rd; b_wr = wr; b_width = w; b_sign = s; b_addr = ad; b_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    drv32(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    drv64(0, 0, 0, 2'd0, 0, 32'h0, 64'h0);
    a_stall = 0; a_squash = 0; a_gnt = 0; a_rvalid = 0; a_rdata = '0;
    b_stall = 0; b_squash = 0; b_gnt = 0; b_rvalid = 0; b_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst.req",  {63'b0, a_req},  64'd0);
    chk("rst.busy", {63'b0, a_busy}, 64'd0);
    q32.push_back('{v: 1'b0, m: 1'b0, d: 64'h0});
    pop32("rst.wb32");
    q64.push_back('{v: 1'b0, m: 1'b0, d: 64'h0});
    pop64("rst.wb64");

    // LB signed from lane 3: gnt cycle 1, rvalid cycle 2, MEM/WB end of cycle 3
    drv32(1, 1, 0, 2'd0, 1, 32'h0000_1003, 32'h0);
    #1;
    chk("lb.busy_c0", {63'b0, a_busy}, 64'd1);
    q32.push_back('{v: 1'b1, m: 1'b0, d: 64'hFFFF_FF80});
    tick();
    chk("lb.req_c1",  {63'b0, a_req}, 64'd1);
    chk("lb.be",      {60'b0, a_be},  64'h8);
    chk("lb.addr",    {32'b0, a_daddr}, 64'h1000);
    chk("lb.we",      {63'b0, a_we},  64'd0);
    a_gnt = 1;
    tick();
    a_gnt = 0; a_rvalid = 1; a_rdata = 32'h8011_2233;
    chk("lb.req_c2", {63'b0, a_req}, 64'd0);
    tick();
    a_rvalid = 0;
    chk("lb.vo_c3_before", {63'b0, a_vo}, 64'd0);
    tick();
    drv32(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    pop32("lb.wb");

    // Misaligned LW and LD on XLEN=32: no bus activity
    drv32(1, 1, 0, 2'd2, 0, 32'h0000_1002, 32'h0);
    #1;
    chk("lw_mis.req",  {63'b0, a_req},  64'd0);
    chk("lw_mis.busy", {63'b0, a_busy}, 64'd0);
    q32.push_back('{v: 1'b1, m: 1'b1, d: 64'h0});
    tick();
    pop32("lw_mis.wb");
    drv32(1, 1, 0, 2'd3, 0, 32'h0000_1000, 32'h0);
    #1;
    chk("ld32.req", {63'b0, a_req}, 64'd0);
    q32.push_back('{v: 1'b1, m: 1'b1, d: 64'h0});
    tick();
    pop32("ld32.wb");

    // LHU with delayed grant and response arriving under stall
    drv32(1, 1, 0, 2'd1, 0, 32'h0000_1002, 32'h0);
    q32.push_back('{v: 1'b1, m: 1'b0, d: 64'h0000_F00D});
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lhu.req_hold",  {63'b0, a_req},  64'd1);
      chk("lhu.addr_hold", {32'b0, a_daddr}, 64'h1000);
      chk("lhu.be_hold",   {60'b0, a_be},  64'hC);
      tick();
    end
    a_gnt = 1;
    tick();
    a_gnt = 0; a_stall = 1; a_rvalid = 1; a_rdata = 32'hF00D_1234;
    tick();
    a_rvalid = 0;
    chk("lhu.busy_done", {63'b0, a_busy}, 64'd0);
    tick();
    tick();
    chk("lhu.stall_hold_mis", {63'b0, a_mis}, 64'd1);
    chk("lhu.stall_hold_ld",  {32'b0, a_ld},  64'd0);
    a_stall = 0;
    tick();
    drv32(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    pop32("lhu.wb");

    // Squash while in REQ: transaction completes, valid_o loads 0
    drv32(1, 1, 0, 2'd2, 0, 32'h0000_1004, 32'h0);
    q32.push_back('{v: 1'b0, m: 1'b0, d: 64'h1234_5678});
    tick();
    a_squash = 1; a_gnt = 1;
    #1;
    chk("sq_req.req", {63'b0, a_req}, 64'd1);
    tick();
    a_squash = 0; a_gnt = 0; a_rvalid = 1; a_rdata = 32'h1234_5678;
    tick();
    a_rvalid = 0;
    tick();
    drv32(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    pop32("sq_req.wb");

    // Squash in IDLE suppresses the request
    drv32(1, 0, 1, 2'd2, 0, 32'h0000_1010, 32'hCAFE_F00D);
    a_squash = 1;
    #1;
    chk("sq_idle.req",  {63'b0, a_req},  64'd0);
    chk("sq_idle.busy", {63'b0, a_busy}, 64'd0);
    q32.push_back('{v: 1'b0, m: 1'b0, d: 64'h0});
    tick();
    a_squash = 0;
    drv32(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    chk("sq_idle.req_after", {63'b0, a_req}, 64'd0);
    pop32("sq_idle.wb");

    // Reset while in RSP, late rvalid ignored
    drv32(1, 1, 0, 2'd2, 0, 32'h0000_1008, 32'h0);
    tick();
    a_gnt = 1;
    tick();
    a_gnt = 0; rst = 1;
    tick();
    rst = 0;
    drv32(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    a_rvalid = 1; a_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_rsp.req",  {63'b0, a_req},  64'd0);
    chk("rst_rsp.busy", {63'b0, a_busy}, 64'd0);
    q32.push_back('{v: 1'b0, m: 1'b0, d: 64'h0});
    tick();
    a_rvalid = 0;
    chk("rst_rsp.req_after", {63'b0, a_req}, 64'd0);
    pop32("rst_rsp.wb");

    // XLEN=64 SH at lane 6: store goes straight to DONE
    drv64(1, 0, 1, 2'd1, 0, 32'h0000_2006, 64'h0000_0000_0000_ABCD);
    q64.push_back('{v: 1'b1, m: 1'b0, d: 64'h0});
    tick();
    chk("sh64.req",   {63'b0, b_req}, 64'd1);
    chk("sh64.be",    {56'b0, b_be},  64'hC0);
    chk("sh64.wdata", b_dwdata,       64'hABCD_0000_0000_0000);
    chk("sh64.addr",  {32'b0, b_daddr}, 64'h2000);
    chk("sh64.we",    {63'b0, b_we},  64'd1);
    b_gnt = 1;
    tick();
    b_gnt = 0;
    chk("sh64.done_busy", {63'b0, b_busy}, 64'd0);
    chk("sh64.done_req",  {63'b0, b_req},  64'd0);
    tick();
    drv64(0, 0, 0, 2'd0, 0, 32'h0, 64'h0);
    pop64("sh64.wb");

    // XLEN=64 LW signed from upper word sign-extends from bit 31
    drv64(1, 1, 0, 2'd2, 1, 32'h0000_3004, 64'h0);
    q64.push_back('{v: 1'b1, m: 1'b0, d: 64'hFFFF_FFFF_8000_0001});
    tick();
    chk("lw64.be", {56'b0, b_be}, 64'hF0);
    b_gnt = 1;
    tick();
    b_gnt = 0; b_rvalid = 1; b_rdata = 64'h8000_0001_0000_0000;
    tick();
    b_rvalid = 0;
    tick();
    drv64(0, 0, 0, 2'd0, 0, 32'h0, 64'h0);
    pop64("lw64.wb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Parametrised load/store memory stage with a full request/grant/response data-bus handshake.
- Generates byte enables and lane-aligned store data.
- Aligns and sign/zero-extends load data for XLEN=32 or 64.
- Flags misaligned accesses instead of issuing them.
- Captures late responses even while downstream is stalled.
- Sits between execute and writeback and drives the MEM/WB pipeline register.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ADDR_W, 32, data-bus address width.
NBYTES, XLEN/8, localparam: byte lanes.
LANE_W, log2(NBYTES), localparam: lane-select bits.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  instruction in stage is valid
mem_read_i  in  1  load
mem_write_i  in  1  store (read and write never both set)
mem_width_i  in  2  BYTE=0, HALF=1, WORD=2, DOUBLE=3
mem_sign_i  in  1  1 = sign-extend load
addr_i  in  ADDR_W  effective address
wdata_i  in  XLEN  store data, LSB-justified
stall_i  in  1  hold MEM/WB register
squash_i  in  1  kill instruction in stage
dmem_req_o  out  1  bus request
dmem_gnt_i  in  1  bus grant
dmem_we_o  out  1  write request
dmem_addr_o  out  ADDR_W  address, aligned down to NBYTES
dmem_be_o  out  NBYTES  byte enables
dmem_wdata_o  out  XLEN  lane-shifted store data
dmem_rvalid_i  in  1  read response valid
dmem_rdata_i  in  XLEN  read response data
valid_o  out  1  MEM/WB valid
load_data_o  out  XLEN  formatted load result
misalign_o  out  1  MEM/WB misaligned/illegal access flag
busy_o  out  1  to hazard unit: hold upstream, do not advance

Behaviour:
- Reset: state=IDLE; valid_o, misalign_o, dmem_req_o = 0; load_data_o = 0; result register = 0.
- Reset mid-transaction: abandon it; a late rvalid seen in IDLE is ignored.
- access = valid_i & (mem_read_i | mem_write_i).
- Misaligned when any of:
  - HALF with addr[0] set;
  - WORD with addr[1:0] != 0;
  - DOUBLE with addr[2:0] != 0;
  - DOUBLE when XLEN=32.
- States:
  - IDLE: access & aligned & !squash_i -> latch addr/be/wdata/we/width/sign, go to REQ.
  - REQ: dmem_req_o=1 with latched signals held stable. On dmem_gnt_i: store -> DONE, load -> RSP.
  - RSP: on dmem_rvalid_i, capture the formatted load into the result register (independent of stall_i), go to DONE.
  - DONE: wait for !stall_i, then go to IDLE.
- busy_o = (state==REQ) | (state==RSP) | (IDLE & access & aligned & !squash_i).
- MEM/WB register loads when !stall_i & !busy_o:
  - valid_o <= valid_i & ~squash_i;
  - misalign_o <= access & misaligned;
  - load_data_o <= result register if in DONE and a load, else 0.
- Non-memory instructions and misaligned accesses pass through IDLE with no bus activity.
- Minimum load latency: issue cycle 0, req cycle 1, gnt cycle 1, rvalid cycle 2, DONE cycle 3, MEM/WB updates at the end of cycle 3.
- Squash timing:
  - Squash in IDLE suppresses the request.
  - Squash in REQ/RSP does not withdraw the request: req is held until gnt and the transaction completes, but valid_o loads as 0.
- Store lanes: lane = addr[LANE_W-1:0]; dmem_be_o = ((1<<(1<<width))-1) << lane; wdata_i is shifted left by lane*8.
- Load format: extract (1<<width) bytes starting at lane; extend to XLEN (sign if mem_sign_i, else zero). WORD on XLEN=64 sign-extends from bit 31.
- Bus: dmem_addr_o low LANE_W bits = 0. Outputs are don't-care when dmem_req_o=0.

Decomposition:
- Package mem_pkg: mem_width_e (BYTE/HALF/WORD/DOUBLE), mem_sign_e (UNSIGNED/SIGNED), lsu_state_e (IDLE/REQ/RSP/DONE), width-to-size function.
- Sub-module load_align, parametrised by XLEN: combinational extract and extend.
- Be/wdata generation stays inline.

Test Plan:
1. XLEN=32, LB addr 0x1003 signed, rdata 0x80_11_22_33 -> be=0b1000; load_data_o=0xFFFFFF80; valid_o=1 at end of cycle 3 with gnt/rvalid at cycles 1/2.
2. XLEN=64, SH addr 0x2006, wdata 0xABCD -> dmem_be_o=0xC0, dmem_wdata_o=0xABCD000000000000, dmem_addr_o=0x2000; DONE with no RSP.
3. LW addr 0x1002 -> no dmem_req_o, busy_o=0, misalign_o=1, valid_o=1. On XLEN=32, LD to any address -> misalign_o=1.
4. LHU addr 0x1002, gnt delayed 3 cycles, rvalid while stall_i=1 for 4 cycles, rdata 0xF00D1234 -> dmem_req_o held stable; result captured; load_data_o=0x0000F00D after stall release.
5. Squash in REQ -> transaction still completes, valid_o=0. Squash in IDLE -> no dmem_req_o.
6. rst_i asserted in RSP, then rvalid next cycle -> state IDLE, valid_o=0, no spurious result.
